// File: rtl/arm7tdmi_pkg.sv
// Shared types and constants for the ARM7TDMI operand-fetch / shift sequencer.
package arm7tdmi_pkg;

    // Barrel-shifter operation, encoded as in the instruction's shift field.
    typedef enum logic [1:0] {
        SH_LSL = 2'd0,
        SH_LSR = 2'd1,
        SH_ASR = 2'd2,
        SH_ROR = 2'd3
    } shift_type_t;

    // Operand-fetch sequencer states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RS    = 2'd1,
        S_OPS   = 2'd2,
        S_ISSUE = 2'd3
    } seq_state_t;

    // r15 reads as the instruction address plus this offset (two-stage prefetch).
    localparam int PC_READ_OFS    = 8;
    // r15 as Rn/Rm of a register-controlled shift, which costs one extra cycle.
    localparam int PC_READ_OFS_RS = 12;

endpackage

// File: rtl/arm7tdmi_shift_sequencer_if.sv
// Decode, register-file and execute-side signals of the shift sequencer.
// master = surrounding pipeline (decode, register file, execute); slave = sequencer.
interface arm7tdmi_shift_sequencer_if #(
    parameter int XLEN  = 32,
    parameter int AMT_W = 8
);
    import arm7tdmi_pkg::*;

    // Decode side
    logic              in_valid;
    logic              in_ready;
    logic              in_shift_reg;
    logic [3:0]        in_shift_rs;
    logic [3:0]        in_rn;
    logic [3:0]        in_rm;
    shift_type_t       in_shift_type;
    logic [4:0]        in_shift_imm;
    logic              in_imm_en;
    logic [XLEN-1:0]   in_pc;

    // Register file (combinational read)
    logic [3:0]        rf_raddr_a;
    logic [3:0]        rf_raddr_b;
    logic [XLEN-1:0]   rf_rdata_a;
    logic [XLEN-1:0]   rf_rdata_b;

    // Execute side
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_op_a;
    logic [XLEN-1:0]   out_op_b;
    shift_type_t       out_shift_type;
    logic [AMT_W-1:0]  out_shift_amt;
    logic              out_rrx;

    modport master (
        output in_valid, in_shift_reg, in_shift_rs, in_rn, in_rm,
               in_shift_type, in_shift_imm, in_imm_en, in_pc,
               rf_rdata_a, rf_rdata_b, out_ready,
        input  in_ready, rf_raddr_a, rf_raddr_b,
               out_valid, out_op_a, out_op_b, out_shift_type, out_shift_amt, out_rrx
    );

    modport slave (
        input  in_valid, in_shift_reg, in_shift_rs, in_rn, in_rm,
               in_shift_type, in_shift_imm, in_imm_en, in_pc,
               rf_rdata_a, rf_rdata_b, out_ready,
        output in_ready, rf_raddr_a, rf_raddr_b,
               out_valid, out_op_a, out_op_b, out_shift_type, out_shift_amt, out_rrx
    );

endinterface

// File: rtl/arm7tdmi_shift_normalise.sv
// Combinational shifter-command normalisation: turns the encoded shift field
// (immediate or Rs-sourced) into the effective type / amount / RRX request.
module arm7tdmi_shift_normalise
    import arm7tdmi_pkg::*;
#(
    parameter int AMT_W = 8
) (
    input  logic             shift_reg_i,
    input  logic             imm_en_i,
    input  shift_type_t      type_i,
    input  logic [4:0]       imm_i,
    input  logic [7:0]       rs_amt_i,
    output shift_type_t      type_o,
    output logic [AMT_W-1:0] amt_o,
    output logic             rrx_o
);

    // Apply the immediate #0 encodings; register amounts pass through unclipped.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        type_o = type_i;
        amt_o  = AMT_W'(imm_i);
        rrx_o  = 1'b0;
        if (imm_en_i) begin
            type_o = SH_LSL;
            amt_o  = '0;
        end else if (shift_reg_i) begin
            amt_o  = AMT_W'(rs_amt_i);
        end else if (imm_i == 5'd0) begin
            unique case (type_i)
                SH_LSR, SH_ASR: amt_o = AMT_W'(32);
                SH_ROR: begin
                    rrx_o = 1'b1;
                    amt_o = AMT_W'(1);
                end
                default: amt_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/arm7tdmi_shift_sequencer.sv
// Operand-fetch sequencer for data-processing instructions. Register-controlled
// shifts spend one extra cycle reading Rs on port A before Rn/Rm are read, so
// only two register-file read ports are needed.
// Optional build macro ARM7TDMI_REGSHIFT_PC12_EN: in register-shift instructions
// Rn/Rm == r15 reads in_pc+12 instead of in_pc+8 (Rs == r15 always reads in_pc+8).
module arm7tdmi_shift_sequencer
    import arm7tdmi_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int AMT_W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    output logic                         busy,
    arm7tdmi_shift_sequencer_if.slave    bus
);

    seq_state_t        state_q;

    // Instruction fields captured at accept
    logic              shift_reg_q;
    logic              imm_en_q;
    logic [3:0]        rs_q;
    logic [3:0]        rn_q;
    logic [3:0]        rm_q;
    shift_type_t       type_q;
    logic [4:0]        imm_q;
    logic [XLEN-1:0]   pc_q;
    logic [7:0]        rs_amt_q;

    // Registered shifter command
    logic              out_valid_q;
    logic [XLEN-1:0]   op_a_q;
    logic [XLEN-1:0]   op_b_q;
    shift_type_t       type_out_q;
    logic [AMT_W-1:0]  amt_q;
    logic              rrx_q;

    // Combinational next values for the operand / command registers
    logic [XLEN-1:0]   pc_rd_d;
    logic [XLEN-1:0]   pc_ops_d;
    logic [7:0]        rs_amt_d;
    logic [XLEN-1:0]   op_a_d;
    logic [XLEN-1:0]   op_b_d;
    shift_type_t       type_d;
    logic [AMT_W-1:0]  amt_d;
    logic              rrx_d;

    // Read-port addressing: Rs in S_RS, Rn/Rm in S_OPS, parked at r0 otherwise
    always_comb begin
        bus.rf_raddr_a = 4'd0;
        bus.rf_raddr_b = 4'd0;
        unique case (state_q)
            S_RS:    bus.rf_raddr_a = rs_q;
            S_OPS: begin
                bus.rf_raddr_a = rn_q;
                bus.rf_raddr_b = rm_q;
            end
            default: ;
        endcase
    end

    // r15 is not in the register file; substitute the prefetch-adjusted PC
    assign pc_rd_d = pc_q + XLEN'(PC_READ_OFS);
`ifdef ARM7TDMI_REGSHIFT_PC12_EN
    assign pc_ops_d = (shift_reg_q && !imm_en_q) ? pc_q + XLEN'(PC_READ_OFS_RS) : pc_rd_d;
`else
    assign pc_ops_d = pc_rd_d;
`endif

    assign rs_amt_d = (rs_q == 4'd15) ? pc_rd_d[7:0] : bus.rf_rdata_a[7:0];
    assign op_a_d   = (rn_q == 4'd15) ? pc_ops_d : bus.rf_rdata_a;
    assign op_b_d   = imm_en_q        ? '0
                    : (rm_q == 4'd15) ? pc_ops_d : bus.rf_rdata_b;

    arm7tdmi_shift_normalise #(.AMT_W(AMT_W)) u_norm (
        .shift_reg_i (shift_reg_q),
        .imm_en_i    (imm_en_q),
        .type_i      (type_q),
        .imm_i       (imm_q),
        .rs_amt_i    (rs_amt_q),
        .type_o      (type_d),
        .amt_o       (amt_d),
        .rrx_o       (rrx_d)
    );

    // Sequencer FSM with registered command outputs; flush overrides everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            shift_reg_q <= 1'b0;
            imm_en_q    <= 1'b0;
            rs_q        <= 4'd0;
            rn_q        <= 4'd0;
            rm_q        <= 4'd0;
            type_q      <= SH_LSL;
            imm_q       <= 5'd0;
            pc_q        <= '0;
            rs_amt_q    <= 8'd0;
            out_valid_q <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            type_out_q  <= SH_LSL;
            amt_q       <= '0;
            rrx_q       <= 1'b0;
        end else if (flush) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        shift_reg_q <= bus.in_shift_reg;
                        imm_en_q    <= bus.in_imm_en;
                        rs_q        <= bus.in_shift_rs;
                        rn_q        <= bus.in_rn;
                        rm_q        <= bus.in_rm;
                        type_q      <= bus.in_shift_type;
                        imm_q       <= bus.in_shift_imm;
                        pc_q        <= bus.in_pc;
                        rs_amt_q    <= 8'd0;
                        state_q     <= (bus.in_shift_reg && !bus.in_imm_en) ? S_RS : S_OPS;
                    end
                end
                S_RS: begin
                    rs_amt_q <= rs_amt_d;
                    state_q  <= S_OPS;
                end
                S_OPS: begin
                    op_a_q      <= op_a_d;
                    op_b_q      <= op_b_d;
                    type_out_q  <= type_d;
                    amt_q       <= amt_d;
                    rrx_q       <= rrx_d;
                    out_valid_q <= 1'b1;
                    state_q     <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready       = (state_q == S_IDLE);
    assign busy               = (state_q != S_IDLE);
    assign bus.out_valid      = out_valid_q;
    assign bus.out_op_a       = op_a_q;
    assign bus.out_op_b       = op_b_q;
    assign bus.out_shift_type = type_out_q;
    assign bus.out_shift_amt  = amt_q;
    assign bus.out_rrx        = rrx_q;

endmodule

// File: tb/tb_arm7tdmi_shift_sequencer.sv
// Randomised self-checking bench for arm7tdmi_shift_sequencer against a
// behavioural model of the operand/shift rules. Honours ARM7TDMI_REGSHIFT_PC12_EN.
module tb_arm7tdmi_shift_sequencer;
    import arm7tdmi_pkg::*;

    typedef struct {
        bit          regsh;
        int          rs;
        int          rn;
        int          rm;
        int          sh;
        int          imm;
        bit          imm_en;
        logic [31:0] pc;
    } instr_t;

    typedef struct {
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [1:0]  sh;
        logic [7:0]  amt;
        logic        rrx;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic busy;

    logic [31:0] regs [16];
    int n_pass  = 0;
    int n_total = 0;

    arm7tdmi_shift_sequencer_if bus ();

    arm7tdmi_shift_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.rf_rdata_a = regs[bus.rf_raddr_a];
    assign bus.rf_rdata_b = regs[bus.rf_raddr_b];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] rd(input int idx, input int ofs, input logic [31:0] pc);
        return (idx == 15) ? pc + 32'(ofs) : regs[idx];
    endfunction

    function automatic exp_t model(input instr_t i);
        exp_t e;
        int ofs = 8;
`ifdef ARM7TDMI_REGSHIFT_PC12_EN
        if (i.regsh && !i.imm_en) ofs = 12;
`endif
        e.op_a = rd(i.rn, ofs, i.pc);
        e.op_b = i.imm_en ? 32'd0 : rd(i.rm, ofs, i.pc);
        e.sh   = 2'(i.sh);
        e.rrx  = 1'b0;
        if (i.imm_en) begin
            e.sh  = 2'd0;
            e.amt = 8'd0;
        end else if (i.regsh) begin
            e.amt = 8'(rd(i.rs, 8, i.pc) % 256);
        end else if (i.imm == 0 && (i.sh == 1 || i.sh == 2)) begin
            e.amt = 8'd32;
        end else if (i.imm == 0 && i.sh == 3) begin
            e.amt = 8'd1;
            e.rrx = 1'b1;
        end else begin
            e.amt = 8'(i.imm);
        end
        return e;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.regsh  = 1'($urandom_range(0, 1));
        i.rs     = $urandom_range(0, 15);
        i.rn     = $urandom_range(0, 15);
        i.rm     = $urandom_range(0, 15);
        i.sh     = $urandom_range(0, 3);
        i.imm    = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 31);
        i.imm_en = ($urandom_range(0, 4) == 0);
        i.pc     = $urandom & 32'hFFFF_FFFC;
        return i;
    endfunction

    task automatic rand_regs();
        for (int k = 0; k < 16; k++) regs[k] = $urandom;
    endtask

    task automatic scramble_inputs();
        bus.in_shift_reg  = 1'($urandom);
        bus.in_shift_rs   = 4'($urandom);
        bus.in_rn         = 4'($urandom);
        bus.in_rm         = 4'($urandom);
        bus.in_shift_type = shift_type_t'($urandom_range(0, 3));
        bus.in_shift_imm  = 5'($urandom);
        bus.in_imm_en     = 1'($urandom);
        bus.in_pc         = $urandom;
    endtask

    // Present an instruction at a negedge; it is accepted at the following posedge.
    task automatic accept(input instr_t i);
        @(negedge clk);
        bus.in_shift_reg  = i.regsh;
        bus.in_shift_rs   = 4'(i.rs);
        bus.in_rn         = 4'(i.rn);
        bus.in_rm         = 4'(i.rm);
        bus.in_shift_type = shift_type_t'(i.sh);
        bus.in_shift_imm  = 5'(i.imm);
        bus.in_imm_en     = i.imm_en;
        bus.in_pc         = i.pc;
        bus.in_valid      = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        scramble_inputs();
    endtask

    // Full transaction: accept, latency, command contents, optional stall, release.
    task automatic run_instr(input instr_t i, input int stall, input string tag);
        exp_t e;
        int   edges;
        int   want_lat;
        int   want_ra;
        logic [31:0] a0;
        logic [7:0]  m0;
        e        = model(i);
        want_lat = (i.regsh && !i.imm_en) ? 3 : 2;
        want_ra  = (i.regsh && !i.imm_en) ? i.rs : i.rn;
        @(negedge clk);
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL %s in_ready_idle got %b want 1", tag, bus.in_ready); else n_pass++;
        accept(i);
        edges = 1;
        @(negedge clk);
        n_total++; if (bus.rf_raddr_a !== 4'(want_ra)) $display("FAIL %s raddr_a got %0d want %0d", tag, bus.rf_raddr_a, want_ra); else n_pass++;
        while (!bus.out_valid && edges < 8) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        n_total++; if (bus.out_valid !== 1'b1 || edges != want_lat) $display("FAIL %s latency got %0d (valid %b) want %0d", tag, edges, bus.out_valid, want_lat); else n_pass++;
        n_total++; if (bus.out_op_a !== e.op_a) $display("FAIL %s op_a got %h want %h", tag, bus.out_op_a, e.op_a); else n_pass++;
        n_total++; if (bus.out_op_b !== e.op_b) $display("FAIL %s op_b got %h want %h", tag, bus.out_op_b, e.op_b); else n_pass++;
        n_total++; if (bus.out_shift_type !== e.sh) $display("FAIL %s type got %0d want %0d", tag, bus.out_shift_type, e.sh); else n_pass++;
        n_total++; if (bus.out_shift_amt !== e.amt) $display("FAIL %s amt got %0d want %0d", tag, bus.out_shift_amt, e.amt); else n_pass++;
        n_total++; if (bus.out_rrx !== e.rrx) $display("FAIL %s rrx got %b want %b", tag, bus.out_rrx, e.rrx); else n_pass++;
        n_total++; if (bus.rf_raddr_a !== 4'd0 || bus.rf_raddr_b !== 4'd0 || busy !== 1'b1) $display("FAIL %s issue_state got raddr %0d/%0d busy %b want 0/0 1", tag, bus.rf_raddr_a, bus.rf_raddr_b, busy); else n_pass++;
        a0 = bus.out_op_a;
        m0 = bus.out_shift_amt;
        for (int k = 0; k < stall; k++) begin
            @(posedge clk);
            @(negedge clk);
            n_total++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_op_a !== a0 || bus.out_shift_amt !== m0)
                $display("FAIL %s stall%0d got valid %b ready %b op_a %h amt %0d want 1 0 %h %0d", tag, k, bus.out_valid, bus.in_ready, bus.out_op_a, bus.out_shift_amt, a0, m0);
            else n_pass++;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        n_total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL %s release got valid %b ready %b busy %b want 0 1 0", tag, bus.out_valid, bus.in_ready, busy); else n_pass++;
    endtask

    // Watch a few cycles for a command that must never appear.
    task automatic expect_quiet(input int cycles, input string tag);
        int seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen++;
        end
        n_total++; if (seen != 0) $display("FAIL %s quiet got %0d valid cycles want 0", tag, seen); else n_pass++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_total++; if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_rrx !== 1'b0) $display("FAIL reset flags got valid %b busy %b rrx %b want 0 0 0", bus.out_valid, busy, bus.out_rrx); else n_pass++;
        n_total++; if (bus.out_op_a !== 32'd0 || bus.out_op_b !== 32'd0) $display("FAIL reset ops got %h %h want 0 0", bus.out_op_a, bus.out_op_b); else n_pass++;
        n_total++; if (bus.out_shift_amt !== 8'd0 || bus.out_shift_type !== SH_LSL) $display("FAIL reset shift got amt %0d type %0d want 0 0", bus.out_shift_amt, bus.out_shift_type); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b1 || bus.rf_raddr_a !== 4'd0 || bus.rf_raddr_b !== 4'd0) $display("FAIL reset idle got ready %b raddr %0d/%0d want 1 0/0", bus.in_ready, bus.rf_raddr_a, bus.rf_raddr_b); else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_regshift();
        instr_t i = '{regsh:1, rs:3, rn:1, rm:2, sh:0, imm:0, imm_en:0, pc:32'h0000_2000};
        rand_regs();
        regs[3] = 32'h0000_0105;
        run_instr(i, 0, "add_lsl_r3");
    endtask

    task automatic test_imm_shift();
        instr_t i = '{regsh:0, rs:0, rn:0, rm:2, sh:1, imm:0, imm_en:0, pc:32'h0000_3000};
        rand_regs();
        run_instr(i, 0, "mov_lsr0");
        i.sh = 2; run_instr(i, 0, "asr0");
        i.sh = 0; run_instr(i, 0, "lsl0");
        i.sh = 3; i.rm = 4; run_instr(i, 0, "ror0_rrx");
        i.sh = 1; i.imm = 7; run_instr(i, 0, "lsr7");
        i.imm_en = 1; i.sh = 3; i.imm = 0; run_instr(i, 0, "imm_en");
    endtask

    task automatic test_regshift_amounts();
        instr_t i = '{regsh:1, rs:3, rn:5, rm:6, sh:0, imm:0, imm_en:0, pc:32'h0000_4000};
        rand_regs();
        regs[3] = 32'h0000_0100;
        run_instr(i, 0, "reg_lsl_amt0");
        i.sh = 3; run_instr(i, 0, "reg_ror_amt0");
        regs[3] = 32'hFFFF_FFC8;
        i.sh = 1; run_instr(i, 0, "reg_lsr_200");
        regs[3] = 32'h0000_0020;
        i.sh = 2; run_instr(i, 0, "reg_asr_32");
    endtask

    task automatic test_pc_read();
        instr_t i = '{regsh:1, rs:3, rn:1, rm:15, sh:0, imm:0, imm_en:0, pc:32'h0000_1000};
        rand_regs();
        regs[3] = 32'd2;
        run_instr(i, 0, "rm_pc_regshift");
        i.rn = 15; i.rm = 2; run_instr(i, 0, "rn_pc_regshift");
        i.rs = 15; run_instr(i, 0, "rs_pc");
        i.regsh = 0; i.rn = 15; i.rm = 15; i.imm = 4; run_instr(i, 0, "pc_immshift");
    endtask

    task automatic test_stall();
        instr_t i = '{regsh:0, rs:0, rn:7, rm:8, sh:2, imm:9, imm_en:0, pc:32'h0000_5000};
        rand_regs();
        run_instr(i, 4, "stall4");
    endtask

    task automatic test_flush();
        instr_t i = '{regsh:1, rs:3, rn:1, rm:2, sh:0, imm:0, imm_en:0, pc:32'h0000_6000};
        rand_regs();
        // Flush while in S_RS
        accept(i);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_total++; if (busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) $display("FAIL flush_rs got busy %b ready %b valid %b want 0 1 0", busy, bus.in_ready, bus.out_valid); else n_pass++;
        expect_quiet(5, "flush_rs");
        // Reset while in S_OPS
        i.regsh = 0;
        accept(i);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_total++; if (busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) $display("FAIL rst_ops got busy %b ready %b valid %b want 0 1 0", busy, bus.in_ready, bus.out_valid); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        expect_quiet(5, "rst_ops");
        // Flush in S_ISSUE beats out_ready
        accept(i);
        @(negedge clk);
        @(negedge clk);
        bus.out_ready = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        n_total++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL flush_issue got valid %b busy %b want 0 0", bus.out_valid, busy); else n_pass++;
        // Flush beats in_valid in S_IDLE
        @(negedge clk);
        flush = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL flush_idle got busy %b want 0", busy); else n_pass++;
        expect_quiet(4, "flush_idle");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            rand_regs();
            run_instr(rand_instr(), $urandom_range(0, 2), $sformatf("rand%0d", n));
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        scramble_inputs();
        rand_regs();
        test_reset();
        test_regshift();
        test_imm_shift();
        test_regshift_amounts();
        test_pc_read();
        test_stall();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
